cmos_pixel_packer: RTL and testbench
====================================

// Module: cmos_pixel_packer
// PURPOSE
//  Packs one camera's 24-bit pixel stream (cmos_vsync/href/clken/data) into 128-bit words for that channel's frame-buffer write FIFO.
//  Sits directly downstream of each sim_cmos/camera source and upstream of the AXI write master inside the stitching top.
//  Runs entirely in the camera clock domain; frame-aligned; absorbs short sink stalls and counts lost words.
// PARAMETERS
//  DATA_WIDTH      24    pixel width (RGB888)
//  AXI_DATA_WIDTH  128   output word width; PIX_PER_WORD = AXI_DATA_WIDTH/32 (=4)
//  IMG_HDISP       1920  active pixels per line; must be a multiple of PIX_PER_WORD (960/1920 legal)
//  IMG_VDISP       1080  active lines per frame
//  OVF_WIDTH       16    width of overflow counter
// PORTS
//  clk         in   1    camera pixel clock
//  rst_n       in   1    asynchronous active-low reset
//  enable      in   1    capture enable; sampled only at frame start
//  cmos_vsync  in   1    frame sync; rising edge = start of frame
//  cmos_href   in   1    line active
//  cmos_clken  in   1    pixel valid qualifier
//  cmos_data   in   24   pixel {R,G,B}
//  out_valid   out  1    word available
//  out_ready   in   1    sink accepts word (out_valid&&out_ready = transfer)
//  out_data    out  128  packed word; pixel k in bits [32k+23:32k], bits [32k+31:32k+24]=0
//  out_sof     out  1    word is first of frame
//  out_eol     out  1    word is last of a line
//  frame_done  out  1    1-cycle pulse when last word of line IMG_VDISP-1 is written to the buffer
//  ovf_cnt     out  16   words dropped due to full buffer; saturates at all-ones
//  busy        out  1    state != IDLE/WAIT_SOF
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_data=0, out_sof=0, out_eol=0, frame_done=0, ovf_cnt=0, busy=0; pack/pixel/line counters=0.
//  Pixel accepted iff state==ACTIVE && cmos_href && cmos_clken; vsync edge detect uses 1-cycle registered vsync.
//  FSM: IDLE -> WAIT_SOF when enable=1. WAIT_SOF -> ACTIVE on vsync rising edge if enable=1, else -> IDLE.
//       ACTIVE -> WAIT_SOF after frame_done, or on a new vsync rising edge (truncated frame: counters cleared, partial word discarded, no frame_done).
//       enable deassert mid-frame: no effect until frame end.
//  Packing: pixel counter 0..PIX_PER_WORD-1; word completes on 4th accepted pixel -> pushed into 2-entry output FIFO next cycle (latency 1 clk from 4th pixel to out_valid).
//  Word tags: sof=1 on first word after SOF; eol=1 when x counter reaches IMG_HDISP-1; x wraps to 0, line counter++ on eol.
//  href falling with partial word (short line): pad remaining lanes with 0, push with eol=1, advance line; x resets.
//  Extra pixels beyond IMG_HDISP in a line: ignored.
//  Output FIFO: 2 entries, first-word-fall-through; push and pop in same cycle when full: pop wins first, push succeeds.
//  Push when full and no pop: word dropped, ovf_cnt++ (saturating); line/frame counters still advance; frame_done still pulses.
//  out_data/out_sof/out_eol stable while out_valid && !out_ready (AXI-stream rules).
//  Throughput: 1 word per 4 pixels; sink stall tolerance >= 2 word times without loss.
// STRUCTURE
//  Shared package (video_stitch_pkg): PIX_PER_WORD, pixel/word typedefs, packer state enum {IDLE,WAIT_SOF,ACTIVE}.
//  One sub-module: pp_out_fifo (2-entry FWFT FIFO, width AXI_DATA_WIDTH+2, full/empty flags).
//  Top holds FSM, vsync edge detect, lane shift register, x/y counters, ovf counter.
// TESTING
//  1 Reset mid-frame with out_valid=1 -> all outputs return to reset values asynchronously; next frame needs fresh vsync edge.
//  2 IMG_HDISP=8, IMG_VDISP=2, pixels 0x000001..0x000010, out_ready=1 -> 4 words; word0=0x00000004_00000003_00000002_00000001, sof on word0, eol on words 1,3, frame_done once after word 3.
//  3 Same frame, out_ready=0 throughout -> 2 words held, ovf_cnt=2, frame_done still pulses; release -> words 0,1 drained in order.
//  4 Short line: href drops after 6 pixels (HDISP=8) -> word1 lanes 2,3 = 0, eol=1, line counter advances.
//  5 vsync rising edge at line 1 of a 2-line frame -> no frame_done, next word carries sof, ovf_cnt unchanged.
//  6 enable=0 before SOF -> no out_valid for entire frame; enable=1 mid-frame -> capture starts only at next vsync edge.

Source files
------------

// File: rtl/cmos_pixel_packer_pkg.sv
// Shared types and constants for the camera pixel packer:
// lane geometry, pixel/word types and the packer state encoding.
package cmos_pixel_packer_pkg;

   localparam int LANE_WIDTH   = 32;
   localparam int PIX_PER_WORD = 4;

   typedef logic [23:0]  pixel_t;
   typedef logic [127:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_ACTIVE
   } pp_state_e;

endpackage

// File: rtl/cmos_pixel_packer_if.sv
// Output word stream of the packer: valid/ready handshake plus frame/line tags.
interface cmos_pixel_packer_if #(
   parameter int AXI_DATA_WIDTH = 128
);
   logic                      out_valid;
   logic                      out_ready;
   logic [AXI_DATA_WIDTH-1:0] out_data;
   logic                      out_sof;
   logic                      out_eol;

   modport master (output out_valid, output out_data, output out_sof, output out_eol,
                   input  out_ready);
   modport slave  (input  out_valid, input  out_data, input  out_sof, input  out_eol,
                   output out_ready);
endinterface

// File: rtl/cmos_pixel_packer_fifo.sv
// Two-entry first-word-fall-through FIFO; a push into a full FIFO succeeds
// only when the head is popped in the same cycle.
module pp_out_fifo #(
   parameter int WIDTH = 130
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             pop_ok;
   logic             push_ok;

   assign full     = (cnt_q == 2'd2);
   assign empty    = (cnt_q == 2'd0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // When full, the write slot equals the head being popped, so overwriting it is safe.
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = !wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = !rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs a camera's 24-bit pixel stream into tagged 128-bit words, frame-aligned
// on vsync, buffered in a small output FIFO with a saturating drop counter.
module cmos_pixel_packer
   import cmos_pixel_packer_pkg::*;
#(
   parameter int DATA_WIDTH     = 24,
   parameter int AXI_DATA_WIDTH = 128,
   parameter int IMG_HDISP      = 1920,
   parameter int IMG_VDISP      = 1080,
   parameter int OVF_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  cmos_vsync,
   input  logic                  cmos_href,
   input  logic                  cmos_clken,
   input  logic [DATA_WIDTH-1:0] cmos_data,
   cmos_pixel_packer_if.master   out_if,
   output logic                  frame_done,
   output logic [OVF_WIDTH-1:0]  ovf_cnt,
   output logic                  busy
);

   localparam int PPW = AXI_DATA_WIDTH / LANE_WIDTH;
   localparam int PW  = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int XW  = $clog2(IMG_HDISP + 1);
   localparam int YW  = $clog2(IMG_VDISP + 1);

   pp_state_e             state_q, state_d;
   logic                  vsync_q, href_q;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [PW-1:0]         pack_q, pack_d;
   logic [DATA_WIDTH-1:0] lane_q [PPW];
   logic [DATA_WIDTH-1:0] lane_d [PPW];
   logic [DATA_WIDTH-1:0] lane_fill [PPW];
   logic                  sof_pend_q, sof_pend_d;
   logic                  line_done_q, line_done_d;
   logic                  frame_done_q, frame_done_d;
   logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;

   logic                      vsync_rise, href_fall;
   logic                      push, push_eol, line_end, clear;
   logic [AXI_DATA_WIDTH-1:0] push_word;
   logic [AXI_DATA_WIDTH+1:0] fifo_out;
   logic                      fifo_full, fifo_empty, pop, drop;

   assign vsync_rise = cmos_vsync && !vsync_q;
   assign href_fall  = href_q && !cmos_href;

   for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
      assign push_word[gi*LANE_WIDTH +: LANE_WIDTH] =
         {{(LANE_WIDTH-DATA_WIDTH){1'b0}}, lane_fill[gi]};
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      pack_d       = pack_q;
      lane_fill    = lane_q;
      sof_pend_d   = sof_pend_q;
      line_done_d  = line_done_q;
      frame_done_d = 1'b0;
      push         = 1'b0;
      push_eol     = 1'b0;
      line_end     = 1'b0;
      clear        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT_SOF;
         end
         ST_WAIT_SOF: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (vsync_rise) begin
               state_d = ST_ACTIVE;
               clear   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (vsync_rise) begin
               state_d = ST_WAIT_SOF;
               clear   = 1'b1;
            end else if (cmos_href && cmos_clken && !line_done_q) begin
               lane_fill[pack_q] = cmos_data;
               line_end = (x_q == XW'(IMG_HDISP - 1));
               x_d      = line_end ? '0 : x_q + XW'(1);
               push_eol = line_end;
               // Hold off further pixels of an over-long line until href drops.
               line_done_d = line_end;
               if (pack_q == PW'(PPW - 1)) begin
                  push   = 1'b1;
                  pack_d = '0;
               end else begin
                  pack_d = pack_q + PW'(1);
               end
            end else if (href_fall) begin
               line_done_d = 1'b0;
               if (!line_done_q && x_q != '0) begin
                  push     = (pack_q != '0);
                  push_eol = 1'b1;
                  line_end = 1'b1;
                  x_d      = '0;
                  pack_d   = '0;
               end
            end
            if (line_end) begin
               if (y_q == YW'(IMG_VDISP - 1)) begin
                  y_d          = '0;
                  frame_done_d = 1'b1;
                  state_d      = ST_WAIT_SOF;
               end else begin
                  y_d = y_q + YW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (push) sof_pend_d = 1'b0;
      if (clear) begin
         x_d         = '0;
         y_d         = '0;
         pack_d      = '0;
         sof_pend_d  = 1'b1;
         line_done_d = 1'b0;
      end
      for (int i = 0; i < PPW; i++) begin
         lane_d[i] = (push || clear) ? '0 : lane_fill[i];
      end
   end

   assign pop  = out_if.out_ready && !fifo_empty;
   assign drop = push && fifo_full && !pop;

   always_comb begin
      ovf_d = ovf_q;
      if (drop && ovf_q != {OVF_WIDTH{1'b1}}) ovf_d = ovf_q + OVF_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         pack_q       <= '0;
         for (int i = 0; i < PPW; i++) lane_q[i] <= '0;
         sof_pend_q   <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= cmos_vsync;
         href_q       <= cmos_href;
         x_q          <= x_d;
         y_q          <= y_d;
         pack_q       <= pack_d;
         for (int i = 0; i < PPW; i++) lane_q[i] <= lane_d[i];
         sof_pend_q   <= sof_pend_d;
         line_done_q  <= line_done_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   pp_out_fifo #(
      .WIDTH (AXI_DATA_WIDTH + 2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({sof_pend_q, push_eol, push_word}),
      .pop       (out_if.out_ready),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_if.out_valid = !fifo_empty;
   assign out_if.out_sof   = fifo_out[AXI_DATA_WIDTH+1];
   assign out_if.out_eol   = fifo_out[AXI_DATA_WIDTH];
   assign out_if.out_data  = fifo_out[AXI_DATA_WIDTH-1:0];
   assign frame_done       = frame_done_q;
   assign ovf_cnt          = ovf_q;
   assign busy             = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench for cmos_pixel_packer with an 8x2 frame geometry.
module tb_cmos_pixel_packer;
   import cmos_pixel_packer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        cmos_vsync = 1'b0;
   logic        cmos_href = 1'b0;
   logic        cmos_clken = 1'b0;
   pixel_t      cmos_data = '0;
   logic        frame_done;
   logic [15:0] ovf_cnt;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int fd_cnt = 0;
   word_t wq[$];
   logic  sq[$];
   logic  eq[$];

   cmos_pixel_packer_if #(.AXI_DATA_WIDTH(128)) bus ();

   cmos_pixel_packer #(
      .DATA_WIDTH(24), .AXI_DATA_WIDTH(128), .IMG_HDISP(8), .IMG_VDISP(2), .OVF_WIDTH(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cmos_vsync (cmos_vsync),
      .cmos_href  (cmos_href),
      .cmos_clken (cmos_clken),
      .cmos_data  (cmos_data),
      .out_if     (bus.master),
      .frame_done (frame_done),
      .ovf_cnt    (ovf_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         $display("xfer %0d data=%h sof=%b eol=%b", wq.size(), bus.out_data, bus.out_sof, bus.out_eol);
         wq.push_back(bus.out_data);
         sq.push_back(bus.out_sof);
         eq.push_back(bus.out_eol);
      end
      if (frame_done) fd_cnt++;
   end

   task automatic check_val(input string tag, input logic [129:0] got, input logic [129:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      wq.delete();
      sq.delete();
      eq.delete();
      fd_cnt = 0;
   endtask

   task automatic send_vsync();
      cmos_vsync = 1'b1;
      tick(2);
      cmos_vsync = 1'b0;
      tick(2);
   endtask

   task automatic send_line(input int n, input pixel_t base);
      for (int i = 0; i < n; i++) begin
         cmos_href  = 1'b1;
         cmos_clken = 1'b1;
         cmos_data  = base + pixel_t'(i);
         tick(1);
      end
      cmos_href  = 1'b0;
      cmos_clken = 1'b0;
      cmos_data  = '0;
      tick(3);
   endtask

   task automatic send_frame(input pixel_t base);
      send_vsync();
      send_line(8, base);
      send_line(8, base + pixel_t'(8));
      tick(4);
   endtask

   task automatic check_word(input string tag, input int idx, input word_t d, input logic s, input logic e);
      word_t gd;
      logic  gs, ge;
      gd = (idx < wq.size()) ? wq[idx] : 'x;
      gs = (idx < sq.size()) ? sq[idx] : 1'bx;
      ge = (idx < eq.size()) ? eq[idx] : 1'bx;
      check_val({tag, ".data"}, 130'(gd), 130'(d));
      check_val({tag, ".sof"}, 130'(gs), 130'(s));
      check_val({tag, ".eol"}, 130'(ge), 130'(e));
   endtask

   initial begin
      bus.out_ready = 1'b1;
      #22;
      check_val("rst.out_valid", 130'(bus.out_valid), 130'(0));
      check_val("rst.out_data", 130'(bus.out_data), 130'(0));
      check_val("rst.frame_done", 130'(frame_done), 130'(0));
      check_val("rst.ovf_cnt", 130'(ovf_cnt), 130'(0));
      check_val("rst.busy", 130'(busy), 130'(0));
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;
      tick(3);

      // Basic 8x2 frame, sink always ready
      clear_mon();
      send_frame(24'h000001);
      check_val("t2.count", 130'(wq.size()), 130'(4));
      check_word("t2.w0", 0, 128'h00000004_00000003_00000002_00000001, 1'b1, 1'b0);
      check_word("t2.w1", 1, 128'h00000008_00000007_00000006_00000005, 1'b0, 1'b1);
      check_word("t2.w2", 2, 128'h0000000c_0000000b_0000000a_00000009, 1'b0, 1'b0);
      check_word("t2.w3", 3, 128'h00000010_0000000f_0000000e_0000000d, 1'b0, 1'b1);
      check_val("t2.frame_done", 130'(fd_cnt), 130'(1));
      check_val("t2.ovf", 130'(ovf_cnt), 130'(0));
      check_val("t2.busy", 130'(busy), 130'(0));

      // Sink stalled for the whole frame
      clear_mon();
      bus.out_ready = 1'b0;
      send_frame(24'h000001);
      check_val("t3.ovf", 130'(ovf_cnt), 130'(2));
      check_val("t3.frame_done", 130'(fd_cnt), 130'(1));
      check_val("t3.hold_valid", 130'(bus.out_valid), 130'(1));
      check_val("t3.hold_data", 130'(bus.out_data), 130'(128'h00000004_00000003_00000002_00000001));
      check_val("t3.hold_sof", 130'(bus.out_sof), 130'(1));
      bus.out_ready = 1'b1;
      tick(4);
      check_val("t3.count", 130'(wq.size()), 130'(2));
      check_word("t3.w0", 0, 128'h00000004_00000003_00000002_00000001, 1'b1, 1'b0);
      check_word("t3.w1", 1, 128'h00000008_00000007_00000006_00000005, 1'b0, 1'b1);
      check_val("t3.drained", 130'(bus.out_valid), 130'(0));

      // Short first line of 6 pixels
      clear_mon();
      send_vsync();
      send_line(6, 24'h000001);
      send_line(8, 24'h000011);
      tick(4);
      check_val("t4.count", 130'(wq.size()), 130'(4));
      check_word("t4.w0", 0, 128'h00000004_00000003_00000002_00000001, 1'b1, 1'b0);
      check_word("t4.w1", 1, 128'h00000000_00000000_00000006_00000005, 1'b0, 1'b1);
      check_word("t4.w2", 2, 128'h00000014_00000013_00000012_00000011, 1'b0, 1'b0);
      check_word("t4.w3", 3, 128'h00000018_00000017_00000016_00000015, 1'b0, 1'b1);
      check_val("t4.frame_done", 130'(fd_cnt), 130'(1));

      // Frame truncated by a vsync edge in the middle of line 1
      clear_mon();
      send_vsync();
      send_line(8, 24'h000001);
      for (int i = 0; i < 3; i++) begin
         cmos_href  = 1'b1;
         cmos_clken = 1'b1;
         cmos_data  = 24'h000009 + pixel_t'(i);
         tick(1);
      end
      cmos_clken = 1'b0;
      cmos_vsync = 1'b1;
      tick(2);
      cmos_href  = 1'b0;
      cmos_vsync = 1'b0;
      tick(4);
      check_val("t5.trunc_count", 130'(wq.size()), 130'(2));
      check_val("t5.trunc_fd", 130'(fd_cnt), 130'(0));
      send_frame(24'h000021);
      check_val("t5.count", 130'(wq.size()), 130'(6));
      check_word("t5.w2", 2, 128'h00000024_00000023_00000022_00000021, 1'b1, 1'b0);
      check_val("t5.frame_done", 130'(fd_cnt), 130'(1));
      check_val("t5.ovf", 130'(ovf_cnt), 130'(2));

      // Capture disabled, then enabled mid-frame
      clear_mon();
      enable = 1'b0;
      tick(2);
      send_frame(24'h000041);
      check_val("t6.off_count", 130'(wq.size()), 130'(0));
      send_vsync();
      send_line(8, 24'h000041);
      enable = 1'b1;
      send_line(8, 24'h000049);
      tick(4);
      check_val("t6.mid_count", 130'(wq.size()), 130'(0));
      check_val("t6.mid_busy", 130'(busy), 130'(0));
      check_val("t6.fd", 130'(fd_cnt), 130'(0));
      send_frame(24'h000051);
      check_val("t6.count", 130'(wq.size()), 130'(4));
      check_word("t6.w0", 0, 128'h00000054_00000053_00000052_00000051, 1'b1, 1'b0);

      // Asynchronous reset mid-frame with a word pending
      clear_mon();
      bus.out_ready = 1'b0;
      send_vsync();
      send_line(4, 24'h000061);
      tick(2);
      check_val("t1.pre_valid", 130'(bus.out_valid), 130'(1));
      check_val("t1.pre_busy", 130'(busy), 130'(1));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("t1.out_valid", 130'(bus.out_valid), 130'(0));
      check_val("t1.out_data", 130'(bus.out_data), 130'(0));
      check_val("t1.out_sof", 130'(bus.out_sof), 130'(0));
      check_val("t1.out_eol", 130'(bus.out_eol), 130'(0));
      check_val("t1.frame_done", 130'(frame_done), 130'(0));
      check_val("t1.ovf", 130'(ovf_cnt), 130'(0));
      check_val("t1.busy", 130'(busy), 130'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick(2);
      clear_mon();
      send_line(8, 24'h000071);
      tick(3);
      check_val("t1.no_sof_count", 130'(wq.size()), 130'(0));
      check_val("t1.no_sof_busy", 130'(busy), 130'(0));
      send_frame(24'h000081);
      check_val("t1.count", 130'(wq.size()), 130'(4));
      check_word("t1.w0", 0, 128'h00000084_00000083_00000082_00000081, 1'b1, 1'b0);
      check_val("t1.frame_done", 130'(fd_cnt), 130'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
